video_timing_gen: RTL and testbench

Raster timing generator for the VGA output path. Free-running horizontal and vertical pixel counters produce `hpos`, `vpos`, `display_on`, `hsync` and `vsync`. These drive the downstream pattern and pixel generators, which turn position and `display_on` into RGB, and the sync pins of the video DAC. Adds a one-cycle frame-start strobe and a frame counter for animation logic.

---
 rtl/video_timing_gen.sv | 131 +++++++++++++
 tb/tb_video_timing_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing generator. Free-running horizontal/vertical
//               pixel counters with registered display-enable, sync outputs,
//               a one-clock frame-start strobe and a completed-frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int   H_DISPLAY    = 256,
    parameter int   H_FRONT      = 7,
    parameter int   H_SYNC       = 23,
    parameter int   H_BACK       = 23,
    parameter int   V_DISPLAY    = 240,
    parameter int   V_FRONT      = 14,
    parameter int   V_SYNC       = 3,
    parameter int   V_BACK       = 5,
    parameter logic HSYNC_ACTIVE = 1'b1,
    parameter logic VSYNC_ACTIVE = 1'b1,
    parameter int   POS_W        = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             display_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    // Raster geometry
    localparam int c_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Terminal counts, sized to the counters
    localparam logic [POS_W-1:0] c_H_LAST = POS_W'(c_H_TOTAL - 1);
    localparam logic [POS_W-1:0] c_V_LAST = POS_W'(c_V_TOTAL - 1);

    // Decode thresholds carry one extra bit so a visible width equal to
    // 2^POS_W still compares correctly against a zero-extended position.
    localparam logic [POS_W:0] c_H_DISP     = (POS_W+1)'(H_DISPLAY);
    localparam logic [POS_W:0] c_V_DISP     = (POS_W+1)'(V_DISPLAY);
    localparam logic [POS_W:0] c_HS_START   = (POS_W+1)'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W:0] c_HS_END     = (POS_W+1)'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W:0] c_VS_START   = (POS_W+1)'(V_DISPLAY + V_FRONT);
    localparam logic [POS_W:0] c_VS_END     = (POS_W+1)'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Registered state
    logic [POS_W-1:0] r_hpos;
    logic [POS_W-1:0] r_vpos;
    logic             r_display_on;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;
    logic [7:0]       r_frame_count;

    // Next-state values
    logic [POS_W-1:0] w_hpos_nxt;
    logic [POS_W-1:0] w_vpos_nxt;
    logic             w_frame_wrap;
    logic             w_display_nxt;
    logic             w_hsync_win;
    logic             w_vsync_win;

    // Counter advance: hpos steps every enabled cycle, vpos steps on line wrap
    always_comb begin
        w_hpos_nxt   = r_hpos;
        w_vpos_nxt   = r_vpos;
        w_frame_wrap = 1'b0;
        if (pix_en) begin
            if (r_hpos == c_H_LAST) begin
                w_hpos_nxt = '0;
                if (r_vpos == c_V_LAST) begin
                    w_vpos_nxt   = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_vpos_nxt = r_vpos + 1'b1;
                end
            end else begin
                w_hpos_nxt = r_hpos + 1'b1;
            end
        end
    end

    // Decode from the next counter values so the registered flags line up
    // with the position they are presented alongside
    always_comb begin
        w_display_nxt = ({1'b0, w_hpos_nxt} < c_H_DISP) &&
                        ({1'b0, w_vpos_nxt} < c_V_DISP);
        w_hsync_win   = ({1'b0, w_hpos_nxt} >= c_HS_START) &&
                        ({1'b0, w_hpos_nxt} <= c_HS_END);
        w_vsync_win   = ({1'b0, w_vpos_nxt} >= c_VS_START) &&
                        ({1'b0, w_vpos_nxt} <= c_VS_END);
    end

    // Output and counter registers; reset forces the raster origin without a strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_display_on  <= 1'b1;
            r_hsync       <= ~HSYNC_ACTIVE;
            r_vsync       <= ~VSYNC_ACTIVE;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_hpos        <= w_hpos_nxt;
            r_vpos        <= w_vpos_nxt;
            r_display_on  <= w_display_nxt;
            r_hsync       <= w_hsync_win ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            r_vsync       <= w_vsync_win ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign display_on  = r_display_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen. Expected outputs are
//               queued as each cycle's stimulus is driven and compared one
//               clock later. A second instance uses active-low sync.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;

    logic [8:0] hpos, vpos;
    logic       display_on, hsync, vsync, frame_start;
    logic [7:0] frame_count;

    logic [8:0] hpos_n, vpos_n;
    logic       display_on_n, hsync_n, vsync_n, frame_start_n;
    logic [7:0] frame_count_n;

    video_timing_gen dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    video_timing_gen #(
        .HSYNC_ACTIVE (1'b0),
        .VSYNC_ACTIVE (1'b0)
    ) dut_n (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hpos        (hpos_n),
        .vpos        (vpos_n),
        .display_on  (display_on_n),
        .hsync       (hsync_n),
        .vsync       (vsync_n),
        .frame_start (frame_start_n),
        .frame_count (frame_count_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int disp;
        int hs;
        int vs;
        int fs;
        int fc;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference raster model
    int m_h  = 0;
    int m_v  = 0;
    int m_fc = 0;
    int m_fs = 0;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Drive one clock of stimulus and queue what the DUT must show after it
    task automatic drive(input bit rst, input bit en);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        pix_en = en;
        if (rst) begin
            m_h = 0; m_v = 0; m_fc = 0; m_fs = 0;
        end else if (en) begin
            m_fs = 0;
            if (m_h == 308) begin
                m_h = 0;
                if (m_v == 261) begin
                    m_v  = 0;
                    m_fs = 1;
                    m_fc = (m_fc + 1) % 256;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
        end else begin
            m_fs = 0;
        end
        e.h    = m_h;
        e.v    = m_v;
        e.disp = (m_h < 256 && m_v < 240) ? 1 : 0;
        e.hs   = (m_h >= 263 && m_h <= 285) ? 1 : 0;
        e.vs   = (m_v >= 254 && m_v <= 256) ? 1 : 0;
        e.fs   = m_fs;
        e.fc   = m_fc;
        q.push_back(e);
    endtask

    // Compare DUT outputs against the oldest queued expectation
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_val("hpos",        int'(hpos),        e.h);
            check_val("vpos",        int'(vpos),        e.v);
            check_val("display_on",  int'(display_on),  e.disp);
            check_val("hsync",       int'(hsync),       e.hs);
            check_val("vsync",       int'(vsync),       e.vs);
            check_val("frame_start", int'(frame_start), e.fs);
            check_val("frame_count", int'(frame_count), e.fc);
            check_val("hsync_lo",    int'(hsync_n),     1 - e.hs);
            check_val("vsync_lo",    int'(vsync_n),     1 - e.vs);
        end
    end

    initial begin
        // Reset held three cycles with pix_en high
        repeat (3) drive(1'b1, 1'b1);
        // Full-rate sweep up to (300,261): 261*309 + 300 enabled cycles
        repeat (80949) drive(1'b0, 1'b1);
        // 1-in-4 duty across the frame wrap
        for (int i = 0; i < 80; i++) drive(1'b0, (i % 4) == 3);
        // Full rate into the next frame, then reset mid-frame
        repeat (459) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        // Random pix_en gaps after reset
        for (int i = 0; i < 700; i++) drive(1'b0, $urandom_range(0, 2) == 0);
        drive(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check_val("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
